// File: rtl/ram_arbiter_wishbone_pkg.sv
// Shared definitions for the two-master RAM arbiter: FSM encodings, master IDs, bus word type.
package ram_arbiter_wishbone_pkg;

  typedef logic [31:0] word_t;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/ram_arbiter_wishbone_if.sv
// Wishbone-style bus bundle; master/slave views for the CPU ports, ram/mem views for the RAM side.
interface ram_arbiter_wishbone_if;
  import ram_arbiter_wishbone_pkg::*;

  logic  cyc;
  logic  stb;
  logic  we;
  word_t adr;
  word_t wdata;
  word_t rdata;
  logic  ack;
  logic  err;

  modport master (output cyc, stb, we, adr, wdata, input rdata, ack, err);
  modport slave  (input cyc, stb, we, adr, wdata, output rdata, ack, err);
  // The RAM has no handshake, so its side carries only strobe, address and data.
  modport ram    (output stb, we, adr, wdata, input rdata);
  modport mem    (input stb, we, adr, wdata, output rdata);
endinterface

// File: rtl/ram_arbiter_wishbone_addr_check.sv
// Rejects misaligned word accesses and any address whose word would run past the end of the RAM.
module ram_arbiter_wishbone_addr_check
  import ram_arbiter_wishbone_pkg::*;
#(
  parameter int unsigned SIZE = 128
) (
  input  word_t adr,
  output logic  err
);

  localparam word_t LAST_WORD = word_t'(SIZE - 4);

  assign err = (adr[1:0] != 2'b00) || (adr > LAST_WORD);

endmodule

// File: rtl/ram_arbiter_wishbone.sv
// Round-robin arbiter with bounded burst lock between the fetch port (m0) and load/store port (m1),
// generating ACK/ERR on behalf of a handshake-less RAM.
module ram_arbiter_wishbone
  import ram_arbiter_wishbone_pkg::*;
#(
  parameter int unsigned SIZE      = 128,
  parameter int unsigned MAX_BURST = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  ram_arbiter_wishbone_if.slave m0,
  ram_arbiter_wishbone_if.slave m1,
  ram_arbiter_wishbone_if.ram   s
);

  localparam int unsigned      CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state, state_nx;
  logic             grant, grant_nx;
  logic             last, last_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic  req0, req1;
  logic  g_cyc, g_stb, g_we;
  word_t g_adr, g_wdata;
  logic  other_req;
  logic  adr_err;
  logic  in_access;
  logic  beat;
  logic  beat_ok;
  logic  beat_err;

  assign req0 = m0.cyc & m0.stb;
  assign req1 = m1.cyc & m1.stb;

  assign g_cyc     = grant ? m1.cyc   : m0.cyc;
  assign g_stb     = grant ? m1.stb   : m0.stb;
  assign g_we      = grant ? m1.we    : m0.we;
  assign g_adr     = grant ? m1.adr   : m0.adr;
  assign g_wdata   = grant ? m1.wdata : m0.wdata;
  assign other_req = grant ? req0     : req1;

  ram_arbiter_wishbone_addr_check #(
    .SIZE (SIZE)
  ) u_addr_check (
    .adr (g_adr),
    .err (adr_err)
  );

  // A beat only exists while the granted master is actually strobing in ACCESS.
  assign in_access = (state == ACCESS);
  assign beat      = in_access & g_cyc & g_stb;
  assign beat_ok   = beat & ~adr_err;
  assign beat_err  = beat & adr_err;

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    last_nx  = last;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          state_nx = ACCESS;
          cnt_nx   = CNT_ONE;
          grant_nx = (req0 & req1) ? ~last : req1;
        end
      end
      ACCESS, HOLD: begin
        // ACCESS and HOLD share the same exit rules; HOLD simply has no beat in flight.
        if (!g_cyc) begin
          state_nx = IDLE;
          last_nx  = grant;
        end else if (!g_stb) begin
          state_nx = HOLD;
        end else if (cnt < CNT_MAX) begin
          state_nx = ACCESS;
          cnt_nx   = cnt + CNT_ONE;
        end else if (other_req) begin
          state_nx = IDLE;
          last_nx  = grant;
        end else begin
          state_nx = ACCESS;
          cnt_nx   = CNT_ONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= M0;
      last  <= M1;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
    end
  end

  assign s.stb   = beat_ok;
  assign s.we    = beat_ok & g_we;
  assign s.adr   = in_access ? g_adr   : '0;
  assign s.wdata = in_access ? g_wdata : '0;

  assign m0.ack   = beat_ok  & (grant == M0);
  assign m0.err   = beat_err & (grant == M0);
  assign m0.rdata = (in_access && grant == M0) ? s.rdata : '0;

  assign m1.ack   = beat_ok  & (grant == M1);
  assign m1.err   = beat_err & (grant == M1);
  assign m1.rdata = (in_access && grant == M1) ? s.rdata : '0;

endmodule

// File: tb/tb_ram_arbiter_wishbone.sv
// Bench for ram_arbiter_wishbone: directed scenarios plus random traffic against a tenure-based reference model.
module tb_ram_arbiter_wishbone;

  localparam int unsigned SIZE      = 128;
  localparam int          MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ram_arbiter_wishbone_if m0_bus ();
  ram_arbiter_wishbone_if m1_bus ();
  ram_arbiter_wishbone_if ram_bus ();

  assign ram_bus.cyc = 1'b0;
  assign ram_bus.ack = 1'b0;
  assign ram_bus.err = 1'b0;

  logic [31:0] mem [0:31] = '{default: 32'h0};
  assign ram_bus.rdata = (ram_bus.adr < 32'(SIZE)) ? mem[ram_bus.adr[6:2]] : 32'h0;
  always @(posedge clk)
    if (ram_bus.stb && ram_bus.we && ram_bus.adr < 32'(SIZE))
      mem[ram_bus.adr[6:2]] <= ram_bus.wdata;

  ram_arbiter_wishbone #(
    .SIZE      (SIZE),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (ram_bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the RAM, whether the owner paused, how long it has held it.
  int          owner;
  bit          paused;
  int          streak;
  int          last_w;
  logic [31:0] ref_mem [0:31];
  int          nx_owner, nx_streak, nx_last;
  bit          nx_paused;
  bit          pend_wr;
  int          pend_idx;
  logic [31:0] pend_dat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a > 32'(SIZE - 4));
  endfunction

  task automatic model_reset();
    owner   = -1;
    paused  = 1'b0;
    streak  = 0;
    last_w  = 1;
    pend_wr = 1'b0;
  endtask

  task automatic drv(input int i, input logic c, input logic s, input logic w,
                     input logic [31:0] a, input logic [31:0] d);
    if (i == 0) begin
      m0_bus.cyc = c; m0_bus.stb = s; m0_bus.we = w; m0_bus.adr = a; m0_bus.wdata = d;
    end else begin
      m1_bus.cyc = c; m1_bus.stb = s; m1_bus.we = w; m1_bus.adr = a; m1_bus.wdata = d;
    end
  endtask

  task automatic step();
    logic        c [2];
    logic        s [2];
    logic        w [2];
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic [31:0] rd [2];
    logic        obs_ack [2];
    logic        obs_err [2];
    bit          req [2];
    bit          ea [2];
    bit          ee [2];
    bit          active, beat, bad;
    bit          e_stb, e_we;
    int          o;
    #1;
    c[0] = m0_bus.cyc; s[0] = m0_bus.stb; w[0] = m0_bus.we; a[0] = m0_bus.adr; d[0] = m0_bus.wdata;
    c[1] = m1_bus.cyc; s[1] = m1_bus.stb; w[1] = m1_bus.we; a[1] = m1_bus.adr; d[1] = m1_bus.wdata;
    rd[0] = m0_bus.rdata; rd[1] = m1_bus.rdata;
    obs_ack[0] = m0_bus.ack; obs_ack[1] = m1_bus.ack;
    obs_err[0] = m0_bus.err; obs_err[1] = m1_bus.err;
    for (int i = 0; i < 2; i++) begin
      req[i] = c[i] && s[i];
      ea[i]  = 1'b0;
      ee[i]  = 1'b0;
    end
    o      = (owner < 0) ? 0 : owner;
    active = (owner >= 0) && !paused;
    beat   = active && c[o] && s[o];
    bad    = bad_addr(a[o]);
    e_stb  = 1'b0;
    e_we   = 1'b0;
    if (beat) begin
      if (bad) ee[o] = 1'b1;
      else begin
        ea[o] = 1'b1;
        e_stb = 1'b1;
        e_we  = w[o];
      end
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ack%0d", i), 32'(obs_ack[i]), 32'(ea[i]));
      chk($sformatf("err%0d", i), 32'(obs_err[i]), 32'(ee[i]));
      if (!active || owner != i) chk($sformatf("dat%0d_idle", i), rd[i], 32'h0);
      else if (beat && !bad && !w[o]) chk($sformatf("dat%0d_read", i), rd[i], ref_mem[a[o][6:2]]);
    end
    chk("s_stb", 32'(ram_bus.stb), 32'(e_stb));
    chk("s_we", 32'(ram_bus.we), 32'(e_we));
    if (e_stb) begin
      chk("s_adr", ram_bus.adr, a[o]);
      chk("s_dat", ram_bus.wdata, d[o]);
    end
    pend_wr = beat && !bad && w[o];
    pend_idx = int'(a[o][6:2]);
    pend_dat = d[o];
    nx_owner = owner; nx_paused = paused; nx_streak = streak; nx_last = last_w;
    if (owner < 0) begin
      if (req[0] || req[1]) begin
        nx_owner  = (req[0] && req[1]) ? 1 - last_w : (req[1] ? 1 : 0);
        nx_streak = 1;
        nx_paused = 1'b0;
      end
    end else if (!c[o]) begin
      nx_owner = -1;
      nx_last  = o;
    end else if (!s[o]) begin
      nx_paused = 1'b1;
    end else begin
      nx_paused = 1'b0;
      if (streak < MAX_BURST) nx_streak = streak + 1;
      else if (req[1 - o]) begin
        nx_owner = -1;
        nx_last  = o;
      end else nx_streak = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    owner = nx_owner; paused = nx_paused; streak = nx_streak; last_w = nx_last;
    if (pend_wr) ref_mem[pend_idx] = pend_dat;
    pend_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle_both();
    drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  logic [6:0]  a0v, a1v;
  logic [31:0] rnd_adr [2];

  initial begin
    #500000;
    $display("FAIL watchdog observed=still_running expected=finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    rst_n = 1'b0;
    idle_both();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ack0", 32'(m0_bus.ack), 32'h0);
    chk("rst_ack1", 32'(m1_bus.ack), 32'h0);
    chk("rst_err1", 32'(m1_bus.err), 32'h0);
    chk("rst_stb", 32'(ram_bus.stb), 32'h0);
    chk("rst_adr", ram_bus.adr, 32'h0);
    chk("rst_dat0", m0_bus.rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset asserted in the middle of an accepted write aborts it.
    drv(1, 1'b1, 1'b1, 1'b1, 32'h20, 32'h12345678);
    step(); tick();
    step();
    chk("pre_rst_ack", 32'(m1_bus.ack), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_stb", 32'(ram_bus.stb), 32'h0);
    chk("midrst_ack", 32'(m1_bus.ack), 32'h0);
    model_reset();
    idle_both();
    @(posedge clk);
    #1;
    chk("midrst_mem", mem[8], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Tie straight after reset goes to M0, the following tie to M1.
    drv(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    drv(1, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
    step(); tick();
    step();
    chk("tie0_m0", 32'(m0_bus.ack), 32'h1);
    chk("tie0_m1", 32'(m1_bus.ack), 32'h0);
    tick();
    idle_both();
    step(); tick();
    drv(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    drv(1, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
    step(); tick();
    step();
    chk("tie1_m1", 32'(m1_bus.ack), 32'h1);
    chk("tie1_m0", 32'(m0_bus.ack), 32'h0);
    tick();
    idle_both();
    step(); tick();

    // Single write then read-back on M1.
    drv(1, 1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    step();
    chk("wr_lat0", 32'(m1_bus.ack), 32'h0);
    tick();
    step();
    chk("wr_ack", 32'(m1_bus.ack), 32'h1);
    tick();
    idle_both();
    step(); tick();
    drv(1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    step(); tick();
    step();
    chk("rd_ack", 32'(m1_bus.ack), 32'h1);
    chk("rd_dat", m1_bus.rdata, 32'hDEADBEEF);
    tick();
    idle_both();
    step(); tick();

    // Burst fairness: M0 streams, M1 waits, M0 is cut after four beats.
    for (int k = 0; k < 10; k++) begin
      drv(0, 1'b1, 1'b1, 1'b0, 32'(4 * k), 32'h0);
      if (k >= 1) drv(1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
      step();
      if (k < 7) begin
        a0v[k] = m0_bus.ack;
        a1v[k] = m1_bus.ack;
      end
      tick();
    end
    chk("burst_m0_acks", 32'(a0v), 32'h1E);
    chk("burst_m1_acks", 32'(a1v), 32'h40);
    idle_both();
    step(); tick();
    step(); tick();

    // Address errors and the last valid word.
    drv(1, 1'b1, 1'b1, 1'b1, 32'h7E, 32'hA5A5A5A5);
    step(); tick();
    step();
    chk("err7e_err", 32'(m1_bus.err), 32'h1);
    chk("err7e_stb", 32'(ram_bus.stb), 32'h0);
    tick();
    idle_both();
    step(); tick();
    chk("err7e_mem", mem[31], 32'h0);
    drv(1, 1'b1, 1'b1, 1'b1, 32'h7C, 32'hCAFEF00D);
    step(); tick();
    step();
    chk("ok7c_ack", 32'(m1_bus.ack), 32'h1);
    tick();
    idle_both();
    step(); tick();
    chk("ok7c_mem", mem[31], 32'hCAFEF00D);
    drv(1, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0);
    step(); tick();
    step();
    chk("err80_err", 32'(m1_bus.err), 32'h1);
    chk("err80_ack", 32'(m1_bus.ack), 32'h0);
    tick();
    idle_both();
    step(); tick();

    // HOLD: M0 pauses its strobe mid-burst while M1 keeps asking.
    for (int k = 0; k < 10; k++) begin
      drv(0, 1'b1, (k < 2 || k > 4), 1'b0, 32'(8 * k), 32'h0);
      if (k >= 1) drv(1, 1'b1, 1'b1, 1'b0, 32'h44, 32'h0);
      step();
      if (k < 7) begin
        a0v[k] = m0_bus.ack;
        a1v[k] = m1_bus.ack;
      end
      tick();
    end
    chk("hold_m0_acks", 32'(a0v), 32'h42);
    chk("hold_m1_acks", 32'(a1v), 32'h0);
    idle_both();
    step(); tick();
    step(); tick();

    // Random traffic from both masters.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        case ($urandom_range(0, 15))
          0:       rnd_adr[i] = 32'h80 + 32'(4 * $urandom_range(0, 3));
          1:       rnd_adr[i] = 32'(4 * $urandom_range(0, 31) + $urandom_range(1, 3));
          default: rnd_adr[i] = 32'(4 * $urandom_range(0, 31));
        endcase
        drv(i, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), rnd_adr[i], $urandom);
      end
      step(); tick();
    end
    idle_both();
    step(); tick();
    step(); tick();
    for (int i = 0; i < 32; i++) chk($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
